// File: rtl/mul_pkg.sv
// Shared types and widths for the pipelined 16x16 multiplier.
// MUL_SIGNED_EN adds the negate flag to the stage-1 payload.
package mul_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  // Stage-1 register contents: conditioned operands plus routing info
  typedef struct packed {
    logic [OP_W-1:0]  mag_a;
    logic [OP_W-1:0]  mag_b;
`ifdef MUL_SIGNED_EN
    logic             neg;
`endif
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
  } s1_payload_t;

  // Unsigned magnitude of x; 0x8000 stays 0x8000 when treated as signed
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] x,
                                                input logic            is_signed);
    magnitude = (is_signed && x[OP_W-1]) ? OP_W'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mul_array16.sv
// Unsigned 16x16 -> 32 combinational shift-add multiplier array.
module mul_array16
  import mul_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product_c
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] addend;
  logic [OP_W-1:0]   rem;

  // One partial product per multiplier bit, walking b from LSB up
  always_comb begin
    acc    = '0;
    addend = PROD_W'(a);
    rem    = b;
    for (int unsigned i = 0; i < OP_W; i++) begin
      if (rem[0]) acc = acc + addend;
      addend = addend << 1;
      rem    = rem >> 1;
    end
    product_c = acc;
  end

endmodule

// File: rtl/mul_pipe_stage.sv
// Two-stage valid/ready multiplier: S1 conditions operands, S2 multiplies and selects a half.
// Define MUL_SIGNED_EN for MULH/MULHSU signed behaviour; otherwise they fall back to MULHU.
module mul_pipe_stage
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  s1_payload_t       s1_q;
  s1_payload_t       s1_d;
  logic              s1_valid;
  logic              s1_valid_d;
  logic              s2_valid_d;
  logic              s1_load_c;
  logic              s2_load_c;
  logic              accept_c;
  logic              s2_take_c;
  mul_op_e           op_c;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] signed_prod_c;
  logic [OP_W-1:0]   result_c;

  assign op_c      = mul_op_e'(in_op);
  assign s2_load_c = !out_valid || out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;
  assign in_ready  = s1_load_c && !flush;
  assign accept_c  = in_valid && in_ready;
  assign s2_take_c = s2_load_c && s1_valid && !flush;

  // Operand conditioning into the S1 payload
`ifdef MUL_SIGNED_EN
  logic a_signed_c;
  logic b_signed_c;

  always_comb begin
    s1_d       = '0;
    a_signed_c = (op_c == MULH) || (op_c == MULHSU);
    b_signed_c = (op_c == MULH);
    s1_d.mag_a = magnitude(in_a, a_signed_c);
    s1_d.mag_b = magnitude(in_b, b_signed_c);
    s1_d.neg   = (a_signed_c & in_a[OP_W-1]) ^ (b_signed_c & in_b[OP_W-1]);
    s1_d.op    = op_c;
    s1_d.tag   = in_tag;
  end
`else
  always_comb begin
    s1_d       = '0;
    s1_d.mag_a = in_a;
    s1_d.mag_b = in_b;
    s1_d.op    = op_c;
    s1_d.tag   = in_tag;
  end
`endif

  // Next-state valids; flush empties both stages regardless of handshakes
  always_comb begin
    s1_valid_d = s1_valid;
    s2_valid_d = out_valid;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load_c) s2_valid_d = s1_valid;
      if (s1_load_c) s1_valid_d = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1_valid  <= s1_valid_d;
      out_valid <= s2_valid_d;
      busy      <= s1_valid_d | s2_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (accept_c) begin
      s1_q <= s1_d;
    end
  end

  mul_array16 u_array (
    .a         (s1_q.mag_a),
    .b         (s1_q.mag_b),
    .product_c (prod_c)
  );

`ifdef MUL_SIGNED_EN
  assign signed_prod_c = s1_q.neg ? PROD_W'(~prod_c + 1'b1) : prod_c;
`else
  assign signed_prod_c = prod_c;
`endif

  assign result_c = (s1_q.op == MUL) ? signed_prod_c[OP_W-1:0]
                                     : signed_prod_c[PROD_W-1:OP_W];

  // Output data only moves when S2 takes a live operation, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (s2_take_c) begin
      out_result <= result_c;
      out_tag    <= s1_q.tag;
    end
  end

endmodule
